// File: rtl/sram_bank_ctrl_pkg.sv
// Shared definitions for the parametrised SRAM bank controller.
// Holds the FSM state encodings, the default parameter values and the
// helpers that derive address-field widths from the bank/macro counts.
package sram_bank_ctrl_pkg;

  // Default configuration, matching the fixed 4-bank/16-macro/8-bit part.
  localparam int DEF_DW       = 8;
  localparam int DEF_MACRO_AW = 10;
  localparam int DEF_NMACRO   = 16;
  localparam int DEF_NBANK    = 4;
  localparam int DEF_RD_LAT   = 1;

  // FSM state encodings; kept as plain constants so older tools read them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  // Width of a field that selects one of n items; never narrower than 1 bit.
  function automatic int fieldWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Host word-address width for a given geometry.
  function automatic int hostAddrWidth(input int nBank, input int nMacro, input int macroAw);
    return fieldWidth(nBank) + fieldWidth(nMacro) + macroAw;
  endfunction

endpackage

// File: rtl/sram_bank_sel_dec.sv
// Decodes the latched {bank, macro} pair into the active-low per-macro chip
// selects and output enables. Purely combinational; all bits stay high when
// no access is in progress, and output enables only drop for reads.
module sram_bank_sel_dec
  import sram_bank_ctrl_pkg::*;
#(
  parameter int NBANK  = DEF_NBANK,
  parameter int NMACRO = DEF_NMACRO,
  localparam int BW    = fieldWidth(NBANK),
  localparam int MW    = fieldWidth(NMACRO)
) (
  input  logic [BW-1:0]           i_bank,
  input  logic [MW-1:0]           i_macro,
  input  logic                    i_active,
  input  logic                    i_read,
  output logic [NBANK*NMACRO-1:0] o_csb,
  output logic [NBANK*NMACRO-1:0] o_oeb
);

  logic [BW+MW-1:0] w_index;

  assign w_index = {i_bank, i_macro};

  // One-cold select of the addressed macro; OEB follows CSB only on reads.
  always_comb begin
    o_csb = '1;
    o_oeb = '1;
    if (i_active) begin
      o_csb[w_index] = 1'b0;
      if (i_read) begin
        o_oeb[w_index] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: valid/ready request channel in, valid/ready read
// response channel out, driving NBANK x NMACRO SRAM macros with shared
// address/data/enable lines and per-macro active-low selects.
// Optional build macro SRAM_BANK_CTRL_STATS_EN adds saturating 16-bit
// accepted-read/accepted-write counters on RD_CNT/WR_CNT.
module sram_bank_ctrl
  import sram_bank_ctrl_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int MACRO_AW = DEF_MACRO_AW,
  parameter int NMACRO   = DEF_NMACRO,
  parameter int NBANK    = DEF_NBANK,
  parameter int RD_LAT   = DEF_RD_LAT,
  localparam int BW      = fieldWidth(NBANK),
  localparam int MW      = fieldWidth(NMACRO),
  localparam int AW      = hostAddrWidth(NBANK, NMACRO, MACRO_AW)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [AW-1:0]           REQ_ADDR,
  input  logic [DW-1:0]           REQ_WDATA,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [DW-1:0]           RSP_RDATA,
  output logic [MACRO_AW-1:0]     MEM_ADDR,
  output logic                    MEM_CE,
  output logic                    MEM_WEB,
  output logic [DW-1:0]           MEM_IDATA,
  output logic [NBANK*NMACRO-1:0] MEM_CSB,
  output logic [NBANK*NMACRO-1:0] MEM_OEB,
  input  logic [NBANK*DW-1:0]     MEM_ODATA
`ifdef SRAM_BANK_CTRL_STATS_EN
  ,
  output logic [15:0]             RD_CNT,
  output logic [15:0]             WR_CNT
`endif
);

  localparam int CW = fieldWidth(RD_LAT);

  state_t             r_state;
  logic               r_we;
  logic [BW-1:0]      r_bank;
  logic [MW-1:0]      r_macro;
  logic [MACRO_AW-1:0] r_addr;
  logic [DW-1:0]      r_wdata;
  logic [DW-1:0]      r_rdata;
  logic [CW-1:0]      r_waitCnt;

  logic               w_accept;
  logic               w_active;
  logic               w_read;
  logic [DW-1:0]      w_bankData;

  // Requests are only taken in IDLE and never while reset is asserted.
  assign REQ_READY = (r_state == ST_IDLE) && !RST;
  assign w_accept  = REQ_VALID && REQ_READY;

  // The macros are driven during the single ACCESS cycle and every WAIT cycle.
  assign w_active  = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
  assign w_read    = !r_we;

  assign MEM_CE    = w_active;
  assign MEM_WEB   = !((r_state == ST_ACCESS) && r_we);
  assign MEM_ADDR  = r_addr;
  assign MEM_IDATA = r_wdata;
  assign RSP_VALID = (r_state == ST_RESP);
  assign RSP_RDATA = r_rdata;

  sram_bank_sel_dec #(
    .NBANK  (NBANK),
    .NMACRO (NMACRO)
  ) u_sel_dec (
    .i_bank   (r_bank),
    .i_macro  (r_macro),
    .i_active (w_active),
    .i_read   (w_read),
    .o_csb    (MEM_CSB),
    .o_oeb    (MEM_OEB)
  );

  // Pick the read-data lane of the bank latched at accept time.
  always_comb begin
    w_bankData = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (r_bank == BW'(b)) begin
        w_bankData = MEM_ODATA[b*DW +: DW];
      end
    end
  end

  // Main sequencer: accept, drive the access, wait out the read latency,
  // capture on the last access edge, then hold the response until taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_bank    <= '0;
      r_macro   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_waitCnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= REQ_WE;
            r_addr  <= REQ_ADDR[MACRO_AW-1:0];
            r_macro <= REQ_ADDR[MACRO_AW +: MW];
            r_bank  <= REQ_ADDR[MACRO_AW+MW +: BW];
            r_wdata <= REQ_WDATA;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_state <= ST_IDLE;
          end else if (RD_LAT > 1) begin
            r_waitCnt <= CW'(RD_LAT - 2);
            r_state   <= ST_WAIT;
          end else begin
            r_rdata <= w_bankData;
            r_state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (r_waitCnt == '0) begin
            r_rdata <= w_bankData;
            r_state <= ST_RESP;
          end else begin
            r_waitCnt <= r_waitCnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (RSP_READY) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_BANK_CTRL_STATS_EN
  logic [15:0] r_rdCnt;
  logic [15:0] r_wrCnt;

  assign RD_CNT = r_rdCnt;
  assign WR_CNT = r_wrCnt;

  // Saturating counts of accepted reads and writes, bumped on the accept edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rdCnt <= '0;
      r_wrCnt <= '0;
    end else if (w_accept) begin
      if (!REQ_WE && (r_rdCnt != 16'hFFFF)) begin
        r_rdCnt <= r_rdCnt + 16'd1;
      end
      if (REQ_WE && (r_wrCnt != 16'hFFFF)) begin
        r_wrCnt <= r_wrCnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed self-checking bench for sram_bank_ctrl. One instance uses the
// default geometry with a behavioural SRAM array; a second instance is built
// with RD_LAT=3 and has its read data driven directly by the tests.
module tb_sram_bank_ctrl;

  logic        CLK;
  logic        RST;

  // Default-geometry instance (RD_LAT=1)
  logic        reqValid, reqReady, reqWe, rspValid, rspReady;
  logic [15:0] reqAddr;
  logic [7:0]  reqWdata, rspRdata, memIdata;
  logic [9:0]  memAddr;
  logic        memCe, memWeb;
  logic [63:0] memCsb, memOeb;
  logic [31:0] memOdata;

  // RD_LAT=3 instance
  logic        reqValid3, reqReady3, reqWe3, rspValid3, rspReady3;
  logic [15:0] reqAddr3;
  logic [7:0]  reqWdata3, rspRdata3, memIdata3;
  logic [9:0]  memAddr3;
  logic        memCe3, memWeb3;
  logic [63:0] memCsb3, memOeb3;
  logic [31:0] memOdata3;

`ifdef SRAM_BANK_CTRL_STATS_EN
  logic [15:0] rdCnt, wrCnt, rdCnt3, wrCnt3;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] memArr [0:65535];

  sram_bank_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(reqValid), .REQ_READY(reqReady), .REQ_WE(reqWe),
    .REQ_ADDR(reqAddr), .REQ_WDATA(reqWdata),
    .RSP_VALID(rspValid), .RSP_READY(rspReady), .RSP_RDATA(rspRdata),
    .MEM_ADDR(memAddr), .MEM_CE(memCe), .MEM_WEB(memWeb), .MEM_IDATA(memIdata),
    .MEM_CSB(memCsb), .MEM_OEB(memOeb), .MEM_ODATA(memOdata)
`ifdef SRAM_BANK_CTRL_STATS_EN
    , .RD_CNT(rdCnt), .WR_CNT(wrCnt)
`endif
  );

  sram_bank_ctrl #(.RD_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(reqValid3), .REQ_READY(reqReady3), .REQ_WE(reqWe3),
    .REQ_ADDR(reqAddr3), .REQ_WDATA(reqWdata3),
    .RSP_VALID(rspValid3), .RSP_READY(rspReady3), .RSP_RDATA(rspRdata3),
    .MEM_ADDR(memAddr3), .MEM_CE(memCe3), .MEM_WEB(memWeb3), .MEM_IDATA(memIdata3),
    .MEM_CSB(memCsb3), .MEM_OEB(memOeb3), .MEM_ODATA(memOdata3)
`ifdef SRAM_BANK_CTRL_STATS_EN
    , .RD_CNT(rdCnt3), .WR_CNT(wrCnt3)
`endif
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural SRAM: writes land on the edge ending the write access
  always @(posedge CLK) begin
    if (memCe && !memWeb) begin
      for (int k = 0; k < 64; k++) begin
        if (!memCsb[k]) memArr[{k[5:0], memAddr}] <= memIdata;
      end
    end
  end

  // Behavioural SRAM: the enabled macro of each bank drives that bank's lane
  always_comb begin
    memOdata = '0;
    for (int b = 0; b < 4; b++) begin
      for (int m = 0; m < 16; m++) begin
        if (!memOeb[b*16+m]) memOdata[b*8 +: 8] = memArr[{b[1:0], m[3:0], memAddr}];
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue a read on the default instance and return the response data
  task automatic doRead(input logic [15:0] addr, output logic [7:0] data, output bit ok);
    ok = 0;
    data = '0;
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = addr; rspReady = 1'b1;
    step();
    reqValid = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (rspValid) begin
        data = rspRdata;
        ok = 1;
      end else begin
        step();
      end
    end
    step();
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [7:0] data);
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = addr; reqWdata = data;
    step();
    reqValid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++; if (reqReady !== 1'b0) $display("[TB] FAIL rst_ready_in_reset got %b want 0", reqReady); else passes++;
    checks++; if ({rspValid, memCe, memWeb} !== 3'b001) $display("[TB] FAIL rst_ctl got %b want 001", {rspValid, memCe, memWeb}); else passes++;
    checks++; if ({memCsb, memOeb} !== {128{1'b1}}) $display("[TB] FAIL rst_sel got %h want all ones", {memCsb, memOeb}); else passes++;
    checks++; if ({memAddr, memIdata, rspRdata} !== 26'd0) $display("[TB] FAIL rst_data got %h want 0", {memAddr, memIdata, rspRdata}); else passes++;
`ifdef SRAM_BANK_CTRL_STATS_EN
    checks++; if ({rdCnt, wrCnt} !== 32'd0) $display("[TB] FAIL rst_stats got %h want 0", {rdCnt, wrCnt}); else passes++;
`endif
    RST = 1'b0;
    #1;
    checks++; if (reqReady !== 1'b1) $display("[TB] FAIL rst_ready_after got %b want 1", reqReady); else passes++;
  endtask

  task automatic test_write_read_low();
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 16'h0000; reqWdata = 8'hA5; rspReady = 1'b1;
    step();
    reqValid = 1'b0;
    checks++; if ({memCe, memWeb, reqReady} !== 3'b100) $display("[TB] FAIL wr0_ctl got %b want 100", {memCe, memWeb, reqReady}); else passes++;
    checks++; if (memCsb !== ~64'h1) $display("[TB] FAIL wr0_csb got %h want %h", memCsb, ~64'h1); else passes++;
    checks++; if (memOeb !== {64{1'b1}}) $display("[TB] FAIL wr0_oeb got %h want all ones", memOeb); else passes++;
    checks++; if (memIdata !== 8'hA5) $display("[TB] FAIL wr0_idata got %h want a5", memIdata); else passes++;
    step();
    checks++; if ({memCe, memWeb, reqReady} !== 3'b011) $display("[TB] FAIL wr0_idle got %b want 011", {memCe, memWeb, reqReady}); else passes++;
    checks++; if (memCsb !== {64{1'b1}}) $display("[TB] FAIL wr0_csb_idle got %h want all ones", memCsb); else passes++;
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 16'h0000;
    step();
    reqValid = 1'b0;
    checks++; if ({memCe, memWeb, memCsb[0], memOeb[0]} !== 4'b1100) $display("[TB] FAIL rd0_access got %b want 1100", {memCe, memWeb, memCsb[0], memOeb[0]}); else passes++;
    checks++; if (rspValid !== 1'b0) $display("[TB] FAIL rd0_early_valid got %b want 0", rspValid); else passes++;
    step();
    checks++; if (rspValid !== 1'b1) $display("[TB] FAIL rd0_valid got %b want 1", rspValid); else passes++;
    checks++; if (rspRdata !== 8'hA5) $display("[TB] FAIL rd0_data got %h want a5", rspRdata); else passes++;
    checks++; if (memCsb !== {64{1'b1}}) $display("[TB] FAIL rd0_csb_resp got %h want all ones", memCsb); else passes++;
    step();
    checks++; if ({rspValid, reqReady} !== 2'b01) $display("[TB] FAIL rd0_done got %b want 01", {rspValid, reqReady}); else passes++;
  endtask

  task automatic test_write_read_high();
    reqValid = 1'b1; reqWe = 1'b1; reqAddr = 16'hFFFF; reqWdata = 8'h3C; rspReady = 1'b1;
    step();
    reqValid = 1'b0;
    checks++; if (memCsb !== ~(64'h1 << 63)) $display("[TB] FAIL wrmax_csb got %h want %h", memCsb, ~(64'h1 << 63)); else passes++;
    checks++; if (memAddr !== 10'h3FF) $display("[TB] FAIL wrmax_addr got %h want 3ff", memAddr); else passes++;
    step();
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 16'hFFFF;
    step();
    reqValid = 1'b0;
    checks++; if ({memCsb, memOeb} !== {~(64'h1 << 63), ~(64'h1 << 63)}) $display("[TB] FAIL rdmax_sel got %h want bit 63 low", {memCsb, memOeb}); else passes++;
    step();
    checks++; if ({rspValid, rspRdata} !== {1'b1, 8'h3C}) $display("[TB] FAIL rdmax_data got %b/%h want 1/3c", rspValid, rspRdata); else passes++;
    step();
  endtask

  task automatic test_read_backpressure();
    doWrite(16'h1234, 8'h77);
    reqValid = 1'b1; reqWe = 1'b0; reqAddr = 16'h1234; rspReady = 1'b0;
    step();
    checks++; if (memCsb !== ~(64'h1 << 4)) $display("[TB] FAIL bp_csb got %h want %h", memCsb, ~(64'h1 << 4)); else passes++;
    reqWe = 1'b1; reqAddr = 16'h0FFF; reqWdata = 8'h99;
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({rspValid, rspRdata} !== {1'b1, 8'h77}) $display("[TB] FAIL bp_hold%0d got %b/%h want 1/77", i, rspValid, rspRdata); else passes++;
      checks++; if ({reqReady, memCe} !== 2'b00) $display("[TB] FAIL bp_block%0d got %b want 00", i, {reqReady, memCe}); else passes++;
      step();
    end
    reqValid = 1'b0; rspReady = 1'b1;
    step();
    checks++; if ({rspValid, reqReady} !== 2'b01) $display("[TB] FAIL bp_release got %b want 01", {rspValid, reqReady}); else passes++;
    checks++; if (memArr[16'h0FFF] !== 8'h00) $display("[TB] FAIL bp_ignored_write got %h want 00", memArr[16'h0FFF]); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] data;
    bit ok;
    reqValid = 1'b1; reqWe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reqAddr = 16'h0100 + 16'(i); reqWdata = 8'h10 + 8'(i);
      checks++; if ({reqReady, memWeb} !== 2'b11) $display("[TB] FAIL b2b_idle%0d got %b want 11", i, {reqReady, memWeb}); else passes++;
      step();
      if (i == 3) reqValid = 1'b0;
      checks++; if ({reqReady, memWeb} !== 2'b00) $display("[TB] FAIL b2b_access%0d got %b want 00", i, {reqReady, memWeb}); else passes++;
      checks++; if ({memAddr, memIdata} !== {10'h100 + 10'(i), 8'h10 + 8'(i)}) $display("[TB] FAIL b2b_bus%0d got %h/%h want %h/%h", i, memAddr, memIdata, 10'h100 + 10'(i), 8'h10 + 8'(i)); else passes++;
      step();
    end
    doRead(16'h0100, data, ok);
    checks++; if (!ok || data !== 8'h10) $display("[TB] FAIL b2b_rd0 got %h (ok=%0d) want 10", data, ok); else passes++;
    doRead(16'h0103, data, ok);
    checks++; if (!ok || data !== 8'h13) $display("[TB] FAIL b2b_rd3 got %h (ok=%0d) want 13", data, ok); else passes++;
  endtask

  task automatic test_rd_lat3();
    memOdata3 = 32'hEEEEEEEE;
    reqValid3 = 1'b1; reqWe3 = 1'b0; reqAddr3 = 16'h4123; rspReady3 = 1'b1;
    step();
    reqValid3 = 1'b0;
    checks++; if ({memCsb3, memOeb3} !== {~(64'h1 << 16), ~(64'h1 << 16)}) $display("[TB] FAIL l3_access_sel got %h want bit 16 low", {memCsb3, memOeb3}); else passes++;
    checks++; if (memAddr3 !== 10'h123) $display("[TB] FAIL l3_addr got %h want 123", memAddr3); else passes++;
    step();
    checks++; if ({memCe3, memCsb3[16], rspValid3} !== 3'b100) $display("[TB] FAIL l3_wait1 got %b want 100", {memCe3, memCsb3[16], rspValid3}); else passes++;
    step();
    checks++; if ({memCe3, memCsb3[16], rspValid3} !== 3'b100) $display("[TB] FAIL l3_wait2 got %b want 100", {memCe3, memCsb3[16], rspValid3}); else passes++;
    memOdata3 = 32'hEEEE5AEE;
    step();
    memOdata3 = 32'hEEEEEEEE;
    checks++; if ({rspValid3, rspRdata3} !== {1'b1, 8'h5A}) $display("[TB] FAIL l3_data got %b/%h want 1/5a", rspValid3, rspRdata3); else passes++;
    checks++; if ({memCe3, memCsb3} !== {1'b0, {64{1'b1}}}) $display("[TB] FAIL l3_deselect got %h want idle", {memCe3, memCsb3}); else passes++;
    step();
    checks++; if ({rspValid3, reqReady3} !== 2'b01) $display("[TB] FAIL l3_done got %b want 01", {rspValid3, reqReady3}); else passes++;
  endtask

  task automatic test_reset_mid_read();
    reqValid3 = 1'b1; reqWe3 = 1'b0; reqAddr3 = 16'h4123; rspReady3 = 1'b0;
    step();
    reqValid3 = 1'b0;
    step();
    checks++; if (memCe3 !== 1'b1) $display("[TB] FAIL mr_in_wait got %b want 1", memCe3); else passes++;
    RST = 1'b1;
    step();
    checks++; if ({memCsb3, memOeb3} !== {128{1'b1}}) $display("[TB] FAIL mr_sel got %h want all ones", {memCsb3, memOeb3}); else passes++;
    checks++; if ({memCe3, memWeb3, rspValid3, reqReady3} !== 4'b0100) $display("[TB] FAIL mr_ctl got %b want 0100", {memCe3, memWeb3, rspValid3, reqReady3}); else passes++;
    checks++; if ({memAddr3, rspRdata3} !== 18'd0) $display("[TB] FAIL mr_data got %h want 0", {memAddr3, rspRdata3}); else passes++;
`ifdef SRAM_BANK_CTRL_STATS_EN
    checks++; if (rdCnt3 !== 16'd0) $display("[TB] FAIL mr_rdcnt got %h want 0", rdCnt3); else passes++;
`endif
    RST = 1'b0;
    #1;
    checks++; if (reqReady3 !== 1'b1) $display("[TB] FAIL mr_ready got %b want 1", reqReady3); else passes++;
    step();
    step();
    checks++; if ({rspValid3, memCe3} !== 2'b00) $display("[TB] FAIL mr_quiet got %b want 00", {rspValid3, memCe3}); else passes++;
  endtask

  // Test sequence
  initial begin
    for (int i = 0; i < 65536; i++) memArr[i] = 8'h00;
    RST = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
    reqValid3 = 1'b0; reqWe3 = 1'b0; reqAddr3 = '0; reqWdata3 = '0; rspReady3 = 1'b0;
    memOdata3 = '0;
    test_reset();
    test_write_read_low();
    test_write_read_high();
    test_read_backpressure();
    test_back_to_back();
    test_rd_lat3();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
